// File: rtl/down_counter_dff.sv
// Loadable down-counter/timer with IDLE/COUNT/DONE control and one-cycle done pulse.
// Optional periodic-tick mode: define DOWN_COUNTER_AUTORELOAD_EN.
module down_counter_dff #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        // load wins in every state, so an in-flight count is aborted without a done pulse
        if (load) begin
            q_d     = load_val;
            state_d = (load_val == '0) ? DONE : COUNT;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_d = load_val;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                COUNT: begin
                    if (en) begin
                        if (q_q == WIDTH'(1)) begin
                            state_d = DONE;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                            q_d = reload_q;
`else
                            q_d = '0;
`endif
                        end else begin
                            q_d = q_q - WIDTH'(1);
                        end
                    end
                end
                DONE: begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                    // Q already holds the reload value; a zero reload cannot re-enter COUNT
                    state_d = (reload_q == '0) ? IDLE : COUNT;
`else
                    state_d = IDLE;
                    q_d     = '0;
`endif
                end
                default: begin
                    state_d = IDLE;
                    q_d     = '0;
                end
            endcase
        end
    end

    assign Q    = q_q;
    assign busy = (state_q == COUNT);
    assign done = (state_q == DONE);
    assign zero = (q_q == '0);

endmodule

// File: tb/tb_down_counter_dff.sv
// Self-checking bench for down_counter_dff: directed vector table, corner sequences,
// and a randomized run against a remaining-count reference model.
module tb_down_counter_dff;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic [W-1:0] Q;
    logic         busy;
    logic         done;
    logic         zero;

    int n_checks;
    int n_fail;

    down_counter_dff #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .Q        (Q),
        .busy     (busy),
        .done     (done),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ld;
        logic [W-1:0] val;
        logic         e;
        logic [W-1:0] eq;
        logic         ebusy;
        logic         edone;
    } vec_t;

    // Reference: remaining count, whether a countdown is active, a pending pulse, and the period
    int  m_left;
    bit  m_active;
    bit  m_pulse;
    int  m_period;

    task automatic model_reset();
        m_left   = 0;
        m_active = 1'b0;
        m_pulse  = 1'b0;
        m_period = 0;
    endtask

    task automatic model_step(input logic ld, input int val, input logic e);
        bit autoreload;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        autoreload = 1'b1;
`else
        autoreload = 1'b0;
`endif
        if (ld) begin
            m_period = val;
            m_left   = val;
            m_active = (val != 0);
            m_pulse  = (val == 0);
        end else if (m_pulse) begin
            m_pulse = 1'b0;
            if (autoreload && m_period != 0) begin
                m_active = 1'b1;
                m_left   = m_period;
            end else begin
                m_active = 1'b0;
                m_left   = 0;
            end
        end else if (m_active && e) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_active = 1'b0;
                m_pulse  = 1'b1;
                if (autoreload) m_left = m_period;
            end
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int eq, input bit eb, input bit ed);
        check({tag, "_Q"}, int'(Q), eq);
        check({tag, "_busy"}, int'(busy), int'(eb));
        check({tag, "_done"}, int'(done), int'(ed));
        check({tag, "_zero"}, int'(zero), int'(eq == 0));
    endtask

    // Drive inputs, take one edge, advance the model and compare just after the edge.
    task automatic step(input logic ld, input logic [W-1:0] val, input logic e, input string tag);
        load     = ld;
        load_val = val;
        en       = e;
        @(posedge clk);
        model_step(ld, int'(val), e);
        #1;
        check_outputs(tag, m_left, m_active, m_pulse);
    endtask

    task automatic do_reset();
        load     = 1'b0;
        load_val = '0;
        en       = 1'b0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs("reset", 0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        vec_t vecs[$];
        int   pulses;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        load     = 1'b0;
        load_val = '0;
        en       = 1'b0;
        #2;

        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, $sformatf("idle%0d", i));

`ifndef DOWN_COUNTER_AUTORELOAD_EN
        // basic countdown from 5
        vecs.push_back('{1'b1, 8'd5, 1'b1, 8'd5, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd4, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0});
        // enable gating
        vecs.push_back('{1'b1, 8'd3, 1'b0, 8'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0});
        // reload mid-count: single done pulse
        vecs.push_back('{1'b1, 8'd8, 1'b1, 8'd8, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd7, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd6, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'd2, 1'b1, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0});
        // zero load: immediate done, never busy
        vecs.push_back('{1'b1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0});
        // load accepted during the DONE cycle
        vecs.push_back('{1'b1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'd2, 1'b0, 8'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0});
        // full-range start, then abort with a zero load
        vecs.push_back('{1'b1, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 8'd254, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            load     = vecs[i].ld;
            load_val = vecs[i].val;
            en       = vecs[i].e;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), int'(vecs[i].eq), vecs[i].ebusy, vecs[i].edone);
        end
`endif

        // async reset mid-count: load 200, reach 150, drop rst between edges
        do_reset();
        step(1'b1, 8'd200, 1'b1, "async_load");
        for (int i = 0; i < 50; i++) step(1'b0, '0, 1'b1, $sformatf("async_cnt%0d", i));
        check("async_pre_Q", int'(Q), 150);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("async_now", 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, $sformatf("async_post%0d", i));
            if (done) pulses++;
        end
        check("async_no_done", pulses, 0);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
        // periodic tick: 4 decrements plus a DONE cycle per period
        step(1'b1, 8'd4, 1'b1, "auto_load");
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b1, $sformatf("auto%0d", i));
            if (done) pulses++;
        end
        check("auto_pulses", pulses, 4);
`endif

        // randomized run against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic         ld;
            logic [W-1:0] v;
            logic         e;
            ld = ($urandom_range(0, 7) == 0);
            v  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 6));
            e  = ($urandom_range(0, 3) != 0);
            step(ld, v, e, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
